vout_dpi: RTL

DPI (parallel RGB) video transmitter and timing generator. It is the output-side counterpart of the board-level video input path.
- Consumes the 4-pixels-per-clock Y8 stream format (32-bit words, valid/ready, byte 0 = leftmost pixel).
- Generates programmable HSYNC/VSYNC/DE timing.
- Serialises one pixel per clock onto an 18-bit RGB666 bus.
- Drives a DPI panel, or loops back into the input path for bench and bring-up.

---
 rtl/vout_dpi_if.sv | 8 +
 rtl/vout_dpi.sv | 108 ++++++++++
 2 files changed

// File: rtl/vout_dpi_if.sv
// vout_dpi_if: 4-pixel Y8 word stream (byte 0 = leftmost pixel) with valid/ready handshake
interface vout_dpi_if;
    logic [31:0] in_pixel;
    logic        in_valid;
    logic        in_ready;
    modport master (output in_pixel, in_valid, input in_ready);
    modport slave  (input in_pixel, in_valid, output in_ready);
endinterface

// File: rtl/vout_dpi.sv
// vout_dpi: DPI RGB666 transmitter with free-running HSYNC/VSYNC/DE timing fed by a 4-pixel Y8 stream
// Define VOUT_DPI_TESTPAT_EN to add a testpat input that replaces the stream with a ramp pattern.
module vout_dpi #(
    parameter int   H_ACTIVE = 1600,
    parameter int   H_FP     = 48,
    parameter int   H_SYNC   = 32,
    parameter int   H_BP     = 80,
    parameter int   V_ACTIVE = 1200,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 26,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef VOUT_DPI_TESTPAT_EN
    input  logic        testpat,
`endif
    vout_dpi_if.slave   s,
    output logic        frame_start,
    output logic        dpi_vsync,
    output logic        dpi_hsync,
    output logic        dpi_de,
    output logic [17:0] dpi_pixel,
    output logic [15:0] underrun_cnt,
    output logic        busy_frame
);
    localparam logic [15:0] HA  = 16'(H_ACTIVE);
    localparam logic [15:0] HS0 = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS1 = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] HT  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] VA  = 16'(V_ACTIVE);
    localparam logic [15:0] VS0 = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS1 = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] VT  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [15:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic [31:0] buf_q;
    logic [23:0] sh;
    logic [7:0]  y, y_str;
    logic        buf_v, buf_v_nxt, rdy_q, armed, tp;
    logic        de_c, hs_c, vs_c, fs_c, demand, accept, vs_line_nxt;

`ifdef VOUT_DPI_TESTPAT_EN
    assign tp = testpat;
    assign y  = testpat ? h_cnt[7:0] ^ {8{v_cnt[4]}} : y_str;
`else
    assign tp = 1'b0;
    assign y  = y_str;
`endif

    // ready comes from registered state only, so an accept never races the demand on the same word
    assign s.in_ready = rdy_q && !tp;

    always_comb begin
        h_nxt       = (h_cnt == HT) ? '0 : h_cnt + 16'd1;
        v_nxt       = (h_cnt != HT) ? v_cnt : (v_cnt == VT) ? '0 : v_cnt + 16'd1;
        de_c        = h_cnt < HA && v_cnt < VA;
        hs_c        = h_cnt >= HS0 && h_cnt < HS1;
        vs_c        = v_cnt >= VS0 && v_cnt < VS1;
        fs_c        = v_cnt == VS0 && h_cnt == '0;
        demand      = de_c && h_cnt[1:0] == 2'd0;
        accept      = s.in_valid && s.in_ready;
        buf_v_nxt   = fs_c ? 1'b0 : accept ? 1'b1 : demand ? 1'b0 : buf_v;
        vs_line_nxt = v_nxt >= VS0 && v_nxt < VS1;
        y_str       = demand ? (buf_v ? buf_q[7:0] : 8'd0) : sh[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            buf_q        <= '0;
            buf_v        <= 1'b0;
            sh           <= '0;
            rdy_q        <= 1'b0;
            armed        <= 1'b1;
            underrun_cnt <= '0;
            busy_frame   <= 1'b0;
            frame_start  <= 1'b0;
            dpi_de       <= 1'b0;
            dpi_pixel    <= '0;
            dpi_hsync    <= ~HS_POL;
            dpi_vsync    <= ~VS_POL;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (accept)
                buf_q <= s.in_pixel;
            buf_v <= buf_v_nxt;
            sh    <= demand ? (buf_v ? buf_q[31:8] : '0) : de_c ? {8'd0, sh[23:8]} : sh;
            rdy_q <= !buf_v_nxt && !vs_line_nxt;
            if (demand && !buf_v && !tp && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
            if (h_cnt == HA - 16'd1 && v_cnt == VA - 16'd1)
                busy_frame <= 1'b0;
            else if (accept && armed)
                busy_frame <= 1'b1;
            armed       <= fs_c || (armed && !accept);
            frame_start <= fs_c;
            dpi_de      <= de_c;
            dpi_pixel   <= de_c ? {3{y[7:2]}} : '0;
            dpi_hsync   <= hs_c ? HS_POL : ~HS_POL;
            dpi_vsync   <= vs_c ? VS_POL : ~VS_POL;
        end
    end
endmodule
